hazard_fwd_unit: RTL and testbench

Pipeline control partner of the EX slice. It keeps a shadow scoreboard of destination registers for the instructions in EX, MEM and WB. From that it produces the registered forwarding selects that EX consumes, along with the load-use stall, branch flush and global freeze signals. It sits beside the ID stage and sees each instruction one cycle before it enters EX. Saturating stall and flush counters are provided for performance debug.

---
 rtl/hazard_fwd_unit.sv | 104 ++++++++++
 tb/tb_hazard_fwd_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding partner of the EX slice: shadows the destinations of EX/MEM/WB,
// issues registered forwarding selects plus load-use stall, branch flush and freeze.
module hazard_fwd_unit #(
    parameter int RW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs0,
    input  logic [RW-1:0]    id_rs1,
    input  logic             id_use0,
    input  logic             id_use1,
    input  logic [RW-1:0]    id_rd,
    input  logic             id_regwrite,
    input  logic             id_load,
    input  logic             ex_branch,
    input  logic             mem_busy,
    output logic [1:0]       fwd_reg0,
    output logic [1:0]       fwd_reg1,
    output logic             stall,
    output logic [1:0]       flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          regwrite;
        logic          load;
    } shadow_t;

    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    logic [1:0]       r_fwd0;
    logic [1:0]       r_fwd1;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [RW-1:0] w_src [2];
    logic [1:0]    w_sel [2];
    logic [1:0]    w_use;
    logic [1:0]    w_ex_hit;
    logic [1:0]    w_mem_hit;
    logic          w_load_use;
    logic          w_flush;

    assign w_src[0] = id_rs0;
    assign w_src[1] = id_rs1;
    assign w_use    = {id_use1, id_use0};

    // WB is never a forwarding source: the register file writes before it reads.
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        assign w_ex_hit[gi]  = w_use[gi] & r_ex.valid & r_ex.regwrite
                             & (r_ex.rd != '0) & (r_ex.rd == w_src[gi]);
        assign w_mem_hit[gi] = w_use[gi] & r_mem.valid & r_mem.regwrite
                             & (r_mem.rd != '0) & (r_mem.rd == w_src[gi]);
        assign w_sel[gi]     = w_ex_hit[gi]  ? 2'b01 :
                               w_mem_hit[gi] ? 2'b10 : 2'b00;
    end

    assign w_load_use = (|w_ex_hit) & r_ex.load;
    assign w_flush    = ex_branch & ~mem_busy;

    assign freeze    = mem_busy;
    assign flush     = {2{w_flush}};
    assign stall     = id_valid & ~ex_branch & ~mem_busy & w_load_use;
    assign fwd_reg0  = r_fwd0;
    assign fwd_reg1  = r_fwd1;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_fwd0      <= 2'b00;
            r_fwd1      <= 2'b00;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_flush || stall) begin
                r_ex   <= '0;
                r_fwd0 <= 2'b00;
                r_fwd1 <= 2'b00;
            end else begin
                r_ex   <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, load: id_load};
                r_fwd0 <= id_valid ? w_sel[0] : 2'b00;
                r_fwd1 <= id_valid ? w_sel[1] : 2'b00;
            end
            if (stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scenario bench for hazard_fwd_unit; a second narrow-counter instance checks saturation.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use0, id_use1, id_regwrite, id_load;
    logic [3:0]  id_rs0, id_rs1, id_rd;
    logic        ex_branch, mem_busy;
    logic [1:0]  fwd_reg0, fwd_reg1, flush;
    logic        stall, freeze;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  s_fwd0, s_fwd1, s_flush;
    logic        s_stall, s_freeze;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] sb_q [$];
    logic [3:0] exp_f;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.RW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
        .id_use0(id_use0), .id_use1(id_use1), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_load(id_load), .ex_branch(ex_branch), .mem_busy(mem_busy),
        .fwd_reg0(fwd_reg0), .fwd_reg1(fwd_reg1), .stall(stall), .flush(flush),
        .freeze(freeze), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    hazard_fwd_unit #(.RW(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
        .id_use0(id_use0), .id_use1(id_use1), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_load(id_load), .ex_branch(ex_branch), .mem_busy(mem_busy),
        .fwd_reg0(s_fwd0), .fwd_reg1(s_fwd1), .stall(s_stall), .flush(s_flush),
        .freeze(s_freeze), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs0 = 0; id_rs1 = 0; id_use0 = 0; id_use1 = 0;
        id_rd = 0; id_regwrite = 0; id_load = 0; ex_branch = 0; mem_busy = 0;
    endtask

    // Drive one instruction in ID and queue the forwarding selects it must get in EX.
    task automatic issue(input logic [3:0] rs0, input logic [3:0] rs1, input logic u0,
                         input logic u1, input logic [3:0] rd, input logic ld,
                         input logic [3:0] exp_fwd);
        id_valid = 1; id_rs0 = rs0; id_rs1 = rs1; id_use0 = u0; id_use1 = u1;
        id_rd = rd; id_regwrite = 1; id_load = ld;
        sb_q.push_back(exp_fwd);
    endtask

    task automatic do_reset();
        idle();
        sb_q.delete();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        #3;
        n_vec++;
        if ({fwd_reg0, fwd_reg1, stall, flush, freeze} !== 8'h00 || stall_cnt !== 0 || flush_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_outputs got=%b/%0d/%0d required=0/0/0",
                     {fwd_reg0, fwd_reg1, stall, flush, freeze}, stall_cnt, flush_cnt);
        end else $display("ok   reset_outputs");
        tick();
        rst = 0;
        issue(4'd1, 4'd2, 1, 1, 4'd3, 0, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd3, 4'd3, 1, 1, 4'd5, 0, 4'b0101);
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL pre_reset_fwd got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   pre_reset_fwd %b", exp_f);
        #2 rst = 1;
        #1;
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_fwd got=%b required=0000", {fwd_reg0, fwd_reg1});
        end else $display("ok   async_reset_fwd");
        tick();
        rst = 0;
        issue(4'd3, 4'd3, 1, 1, 4'd5, 0, 4'b0000);
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL post_reset_no_hazard got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   post_reset_no_hazard");
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(4'd1, 4'd2, 1, 1, 4'd3, 0, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd3, 4'd3, 1, 1, 4'd5, 0, 4'b0101);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_stall got=%b required=0", stall);
        end else $display("ok   b2b_stall");
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL b2b_fwd got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   b2b_fwd %b", exp_f);
        idle();
    endtask

    task automatic test_distance_two();
        do_reset();
        issue(4'd1, 4'd2, 1, 1, 4'd3, 0, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd1, 4'd2, 1, 1, 4'd7, 0, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd3, 4'd1, 1, 1, 4'd6, 0, 4'b1000);
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL dist2_fwd got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   dist2_fwd %b", exp_f);
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(4'd1, 4'd0, 1, 0, 4'd4, 1, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd4, 4'd4, 1, 1, 4'd2, 0, 4'b0000);
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++;
            $display("FAIL lu_stall_on got=%b required=1", stall);
        end else $display("ok   lu_stall_on");
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL lu_bubble_fwd got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   lu_bubble_fwd");
        sb_q.push_back(4'b1010);
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL lu_stall_off got=%b required=0", stall);
        end else $display("ok   lu_stall_off");
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f || stall_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL lu_fwd got=%b/cnt %0d required=%b/cnt 1", {fwd_reg0, fwd_reg1}, stall_cnt, exp_f);
        end else $display("ok   lu_fwd %b stall_cnt=1", exp_f);
        idle();
    endtask

    task automatic test_priority_r0();
        do_reset();
        issue(4'd1, 4'd2, 1, 1, 4'd3, 0, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd1, 4'd2, 1, 1, 4'd3, 0, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd3, 4'd3, 1, 1, 4'd8, 0, 4'b0101);
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL youngest_wins got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   youngest_wins %b", exp_f);
        issue(4'd1, 4'd2, 1, 1, 4'd0, 1, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd0, 4'd0, 1, 1, 4'd9, 0, 4'b0000);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL r0_no_stall got=%b required=0", stall);
        end else $display("ok   r0_no_stall");
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL r0_no_fwd got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   r0_no_fwd");
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        issue(4'd1, 4'd0, 1, 0, 4'd4, 1, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd4, 4'd4, 1, 1, 4'd2, 0, 4'b0000);
        ex_branch = 1;
        #1;
        n_vec++;
        if (flush !== 2'b11 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL br_flush got=%b stall=%b required=11 stall=0", flush, stall);
        end else $display("ok   br_flush");
        tick();
        ex_branch = 0;
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL br_after got=%b fc=%0d sc=%0d required=%b fc=1 sc=0",
                     {fwd_reg0, fwd_reg1}, flush_cnt, stall_cnt, exp_f);
        end else $display("ok   br_after flush_cnt=1");
        // r2 must not be seen in EX (squashed), r4 load now sits in MEM
        issue(4'd2, 4'd4, 1, 1, 4'd6, 0, 4'b0010);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL br_ex_invalid_stall got=%b required=0", stall);
        end else $display("ok   br_ex_invalid_stall");
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL br_ex_invalid_fwd got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   br_ex_invalid_fwd %b", exp_f);
        idle();
    endtask

    task automatic test_freeze();
        do_reset();
        issue(4'd1, 4'd2, 1, 1, 4'd3, 0, 4'b0000);
        tick();
        void'(sb_q.pop_front());
        issue(4'd3, 4'd3, 1, 1, 4'd5, 0, 4'b0101);
        tick();
        void'(sb_q.pop_front());
        issue(4'd5, 4'd3, 1, 1, 4'd6, 0, 4'b0110);
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            ex_branch = (i == 1);
            #1;
            n_vec++;
            if (freeze !== 1'b1 || flush !== 2'b00 || stall !== 1'b0) begin
                n_err++;
                $display("FAIL frz_ctl[%0d] got=%b%b%b required=100", i, freeze, flush, stall);
            end else $display("ok   frz_ctl[%0d]", i);
            tick();
            n_vec++;
            if ({fwd_reg0, fwd_reg1} !== 4'b0101 || stall_cnt !== 0 || flush_cnt !== 0) begin
                n_err++;
                $display("FAIL frz_hold[%0d] got=%b sc=%0d fc=%0d required=0101 sc=0 fc=0",
                         i, {fwd_reg0, fwd_reg1}, stall_cnt, flush_cnt);
            end else $display("ok   frz_hold[%0d]", i);
        end
        mem_busy = 0;
        ex_branch = 0;
        tick();
        exp_f = sb_q.pop_front();
        n_vec++;
        if ({fwd_reg0, fwd_reg1} !== exp_f) begin
            n_err++;
            $display("FAIL frz_resume got=%b required=%b", {fwd_reg0, fwd_reg1}, exp_f);
        end else $display("ok   frz_resume %b", exp_f);
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            issue(4'd1, 4'd0, 1, 0, 4'd4, 1, 4'b0000);
            tick();
            issue(4'd4, 4'd4, 1, 1, 4'd2, 0, 4'b1010);
            tick();
            tick();
            idle();
            tick();
            n_vec++;
            if (stall_cnt !== 16'(i) || s_stall_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin
                n_err++;
                $display("FAIL sat_stall[%0d] got=%0d/%0d required=%0d/%0d",
                         i, stall_cnt, s_stall_cnt, i, (i > 3) ? 3 : i);
            end else $display("ok   sat_stall[%0d] narrow=%0d", i, s_stall_cnt);
        end
        for (int i = 1; i <= 5; i++) begin
            ex_branch = 1;
            tick();
            ex_branch = 0;
            n_vec++;
            if (flush_cnt !== 16'(i) || s_flush_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin
                n_err++;
                $display("FAIL sat_flush[%0d] got=%0d/%0d required=%0d/%0d",
                         i, flush_cnt, s_flush_cnt, i, (i > 3) ? 3 : i);
            end else $display("ok   sat_flush[%0d] narrow=%0d", i, s_flush_cnt);
        end
        sb_q.delete();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_back_to_back();
        test_distance_two();
        test_load_use();
        test_priority_r0();
        test_branch();
        test_freeze();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
